// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and character/segment helpers for the UART echo path.
package uart_pkg;

  localparam logic [1:0] MODE_RAW    = 2'd0;
  localparam logic [1:0] MODE_UPPER  = 2'd1;
  localparam logic [1:0] MODE_HEX    = 2'd2;
  localparam logic [1:0] MODE_SILENT = 2'd3;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHR,
    ST_HI,
    ST_LO,
    ST_SP,
    ST_GUARD
  } echo_state_e;

  // Upper-case ASCII hex digit for a nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    else           return 8'h37 + 8'(n);
  endfunction

  // Fold a..z onto A..Z; everything else passes through.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    else                          return b;
  endfunction

  // Active-low 7-segment pattern, bit0 = segment a.
  function automatic logic [6:0] hex_dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1011000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b0100111;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/uart_echo_buf_if.sv
// Receive/send handshake between the UART character module and the echo buffer.
interface uart_echo_buf_if;
  logic       recv_en;
  logic [7:0] recv_data;
  logic       send_ready;
  logic       send_en;
  logic [7:0] send_data;

  // Drives received bytes and transmitter readiness (UART side).
  modport master (
    output recv_en, recv_data, send_ready,
    input  send_en, send_data
  );

  // Echo buffer side.
  modport slave (
    input  recv_en, recv_data, send_ready,
    output send_en, send_data
  );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module uart_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  // Pointers and level; simultaneous push and pop leave level unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_echo_buf.sv
// Buffers received bytes, echoes them under a selectable mode and shows recent bytes on 7-segment digits.
module uart_echo_buf
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned NUM_DIGITS = 4,
  localparam int unsigned LW         = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  uart_echo_buf_if.slave          bus,
  input  logic [1:0]              mode,
  output logic [LW-1:0]           fifo_level,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex_led
);

  localparam int unsigned HW = 4 * NUM_DIGITS;

  echo_state_e state_q, state_d;
  echo_state_e ret_q, ret_d;
  logic [7:0]  byte_q, byte_d;
  logic [HW-1:0] hist_q;
  logic        push_c, pop_c, full_c, empty_c;
  logic [7:0]  rdata_c;
  logic        tx_en;
  logic [7:0]  tx_data;

  // Full is judged on the start-of-cycle level, so a same-cycle pop never makes room.
  assign push_c = bus.recv_en && !full_c;

  uart_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (bus.recv_data),
    .rdata (rdata_c),
    .full  (full_c),
    .empty (empty_c),
    .level (fifo_level)
  );

  assign bus.send_en   = tx_en;
  assign bus.send_data = tx_data;

  // Sticky drop flag.
  always_ff @(posedge clock) begin
    if (reset)                      overflow <= 1'b0;
    else if (bus.recv_en && full_c) overflow <= 1'b1;
  end

  // History of the most recent bytes, including dropped ones.
  always_ff @(posedge clock) begin
    if (reset)            hist_q <= '0;
    else if (bus.recv_en) hist_q <= (hist_q << 8) | HW'(bus.recv_data);
  end

  // Registered segment decode of the history, one cycle behind it.
  always_ff @(posedge clock) begin
    if (reset) begin
      hex_led <= {NUM_DIGITS{7'b1000000}};
    end else begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        hex_led[7*k +: 7] <= hex_dec(hist_q[4*k +: 4]);
      end
    end
  end

  // Echo FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      byte_q  <= byte_d;
    end
  end

  // Echo FSM next state; send strobe follows send_ready combinationally so it never fires unready.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    byte_d  = byte_q;
    pop_c   = 1'b0;
    tx_en   = 1'b0;
    tx_data = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c  = 1'b1;
          byte_d = rdata_c;
          case (mode)
            MODE_RAW:   state_d = ST_CHR;
            MODE_UPPER: begin
              byte_d  = to_upper(rdata_c);
              state_d = ST_CHR;
            end
            MODE_HEX:    state_d = ST_HI;
            MODE_SILENT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
          endcase
        end
      end
      ST_CHR: begin
        if (bus.send_ready) begin
          tx_en   = 1'b1;
          tx_data = byte_q;
          ret_d   = ST_IDLE;
          state_d = ST_GUARD;
        end
      end
      ST_HI: begin
        if (bus.send_ready) begin
          tx_en   = 1'b1;
          tx_data = nibble_to_ascii(byte_q[7:4]);
          ret_d   = ST_LO;
          state_d = ST_GUARD;
        end
      end
      ST_LO: begin
        if (bus.send_ready) begin
          tx_en   = 1'b1;
          tx_data = nibble_to_ascii(byte_q[3:0]);
          ret_d   = ST_SP;
          state_d = ST_GUARD;
        end
      end
      ST_SP: begin
        if (bus.send_ready) begin
          tx_en   = 1'b1;
          tx_data = ASCII_SPACE;
          ret_d   = ST_IDLE;
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: state_d = ret_q;
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_echo_buf.sv
// Randomised and directed check of uart_echo_buf against a queue-based echo model.
module tb_uart_echo_buf;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned ND    = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      mode;
  logic [LW-1:0]   fifo_level;
  logic            overflow;
  logic [7*ND-1:0] hex_led;

  uart_echo_buf_if bus();

  uart_echo_buf #(.DEPTH(DEPTH), .NUM_DIGITS(ND)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .mode       (mode),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .hex_led    (hex_led)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [7:0]  q_m[$];
  logic [7:0]  out_m[$];
  logic        guard_m = 1'b0;
  logic        ovf_m = 1'b0;
  logic [15:0] hist_m = '0;
  logic [15:0] led_hist_m = '0;
  logic        chk_en = 1'b0;
  int          cyc = 0;
  logic [7:0]  log_d[$];
  int          log_c[$];

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  function automatic logic [7*ND-1:0] leds(input logic [15:0] h);
    logic [7*ND-1:0] r;
    for (int k = 0; k < ND; k++) r[7*k +: 7] = seg_tab[h[4*k +: 4]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_log(input int n, input int bound);
    int i;
    i = 0;
    while (log_d.size() < n && i < bound) begin
      tick();
      i++;
    end
    if (log_d.size() < n) chk("wait_log_timeout", 32'(log_d.size()), 32'(n));
  endtask

  task automatic recv(input logic [7:0] d);
    bus.recv_en = 1'b1;
    bus.recv_data = d;
    tick();
    bus.recv_en = 1'b0;
  endtask

  logic [7:0] up_in  [3] = '{8'h61, 8'h7B, 8'h5A};
  logic [7:0] up_exp [3] = '{8'h41, 8'h7B, 8'h5A};
  logic [7:0] hx_exp [3] = '{8'h41, 8'h35, 8'h20};
  int base;

  initial begin
    reset = 1'b1;
    mode = 2'd0;
    bus.recv_en = 1'b0;
    bus.recv_data = 8'h00;
    bus.send_ready = 1'b0;

    fork
      // Model update on each active edge from the inputs of the closing cycle
      forever begin
        logic sent, idle;
        int   sz;
        logic [7:0] b;
        @(posedge clock);
        cyc++;
        if (reset) begin
          q_m.delete();
          out_m.delete();
          guard_m = 1'b0;
          ovf_m = 1'b0;
          hist_m = '0;
          led_hist_m = '0;
          chk_en = 1'b1;
        end else begin
          sent = (out_m.size() > 0) && !guard_m && bus.send_ready;
          idle = (out_m.size() == 0) && !guard_m;
          sz = q_m.size();
          led_hist_m = hist_m;
          if (sent) begin
            void'(out_m.pop_front());
            guard_m = 1'b1;
          end else begin
            guard_m = 1'b0;
          end
          if (idle && sz > 0) begin
            b = q_m.pop_front();
            case (mode)
              2'd0: out_m.push_back(b);
              2'd1: out_m.push_back((b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b);
              2'd2: begin
                out_m.push_back(asc(b[7:4]));
                out_m.push_back(asc(b[3:0]));
                out_m.push_back(8'h20);
              end
              default: ;
            endcase
          end
          if (bus.recv_en) begin
            if (sz < DEPTH) q_m.push_back(bus.recv_data);
            else            ovf_m = 1'b1;
            hist_m = {hist_m[7:0], bus.recv_data};
          end
        end
      end
      // Compare process, mid-cycle
      forever begin
        logic exp_send;
        @(negedge clock);
        if (chk_en) begin
          exp_send = (out_m.size() > 0) && !guard_m && bus.send_ready;
          chk("send_en", 32'(bus.send_en), 32'(exp_send));
          if (exp_send) chk("send_data", 32'(bus.send_data), 32'(out_m[0]));
          chk("fifo_level", 32'(fifo_level), 32'(q_m.size()));
          chk("overflow", 32'(overflow), 32'(ovf_m));
          chk("hex_led", 32'(hex_led), 32'(leds(led_hist_m)));
          if (bus.send_en === 1'b1) begin
            log_d.push_back(bus.send_data);
            log_c.push_back(cyc);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_send_en", 32'(bus.send_en), 32'd0);
    chk("rst_send_data", 32'(bus.send_data), 32'h00);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_hex_led", 32'(hex_led), 32'({ND{7'b1000000}}));

    // RAW latency: recv in N, send at N+2
    mode = 2'd0;
    bus.send_ready = 1'b1;
    recv(8'h41);
    chk("raw_n1_en", 32'(bus.send_en), 32'd0);
    tick();
    chk("raw_n2_en", 32'(bus.send_en), 32'd1);
    chk("raw_n2_data", 32'(bus.send_data), 32'h41);
    chk("raw_dig0", 32'(hex_led[6:0]), 32'(7'b1111001));
    chk("raw_dig1", 32'(hex_led[13:7]), 32'(7'b0011001));
    tick();
    chk("raw_n3_en", 32'(bus.send_en), 32'd0);

    // UPPER
    repeat (3) tick();
    base = log_d.size();
    mode = 2'd1;
    for (int i = 0; i < 3; i++) recv(up_in[i]);
    wait_log(base + 3, 60);
    if (log_d.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) chk("upper_seq", 32'(log_d[base+i]), 32'(up_exp[i]));
      chk("upper_gap", 32'((log_c[base+1] - log_c[base] >= 2) && (log_c[base+2] - log_c[base+1] >= 2)), 32'd1);
    end

    // HEX with a 10-cycle ready stall before the low nibble
    repeat (3) tick();
    base = log_d.size();
    mode = 2'd2;
    recv(8'hA5);
    wait_log(base + 1, 40);
    bus.send_ready = 1'b0;
    mode = 2'd0;
    repeat (10) tick();
    chk("hex_hold_cnt", 32'(log_d.size()), 32'(base + 1));
    bus.send_ready = 1'b1;
    wait_log(base + 3, 40);
    if (log_d.size() >= base + 3)
      for (int i = 0; i < 3; i++) chk("hex_seq", 32'(log_d[base+i]), 32'(hx_exp[i]));

    // Overflow: engine holds one byte, 17 pulses fill 16 and drop the last
    repeat (5) tick();
    bus.send_ready = 1'b0;
    mode = 2'd0;
    base = log_d.size();
    recv(8'h5C);
    repeat (3) tick();
    chk("ovf_pre_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 17; i++) recv(8'h10 + 8'(i));
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    tick();
    chk("ovf_display", 32'(hex_led), 32'({7'b1111001, 7'b0001110, 7'b0100100, 7'b1000000}));
    bus.send_ready = 1'b1;
    wait_log(base + 17, 200);
    repeat (10) tick();
    chk("ovf_count", 32'(log_d.size()), 32'(base + 17));
    if (log_d.size() >= base + 17) begin
      chk("ovf_first", 32'(log_d[base]), 32'h5C);
      for (int i = 0; i < 16; i++) chk("ovf_order", 32'(log_d[base+1+i]), 32'h10 + 32'(i));
    end
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Randomised traffic, load and readiness varied by segment
    for (int seg = 0; seg < 12; seg++) begin
      int p_recv, p_rdy;
      p_recv = $urandom_range(10, 70);
      p_rdy  = $urandom_range(20, 100);
      mode   = 2'($urandom_range(0, 3));
      for (int c = 0; c < 250; c++) begin
        bus.recv_en    = ($urandom_range(0, 99) < p_recv);
        bus.recv_data  = 8'($urandom_range(0, 255));
        bus.send_ready = ($urandom_range(0, 99) < p_rdy);
        if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
        tick();
      end
    end
    bus.recv_en = 1'b0;
    bus.send_ready = 1'b1;
    repeat (300) tick();

    // Reset while in S_LO with three bytes queued
    mode = 2'd2;
    bus.send_ready = 1'b0;
    for (int i = 0; i < 4; i++) recv(8'hC0 + 8'(i));
    tick();
    chk("mid_level", 32'(fifo_level), 32'd3);
    base = log_d.size();
    bus.send_ready = 1'b1;
    wait_log(base + 1, 20);
    bus.send_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.send_ready = 1'b1;
    #1;
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_send_en", 32'(bus.send_en), 32'd0);
    base = log_d.size();
    repeat (20) tick();
    chk("mid_rst_quiet", 32'(log_d.size()), 32'(base));
    mode = 2'd3;
    for (int i = 0; i < 5; i++) recv(8'h30 + 8'(i));
    repeat (20) tick();
    chk("silent_quiet", 32'(log_d.size()), 32'(base));
    chk("silent_level", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
